// File: rtl/edge_evt_pkg.sv
// Shared mode encodings and sizing helper for the edge event collector.
package edge_evt_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_evt_chan.sv
// One event channel: synchroniser, edge detect and saturating pending counter.
// Optional sticky overflow flag when EDGE_EVENT_COLLECTOR_OVF_EN is defined.
module edge_evt_chan
  import edge_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       line,
  input  edge_mode_e mode,
  input  logic       clr,
  input  logic       dec,
  output logic       pend
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
  , output logic     ovf
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   last, rise, fall, inc, sat;

  // prev_q resets low so a line already high at reset release reads as a rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign last = sync_q[SYNC_STAGES-1];
  assign rise = last & ~prev_q;
  assign fall = ~last & prev_q;
  assign inc  = (rise & (mode == EDGE_RISE || mode == EDGE_BOTH)) |
                (fall & (mode == EDGE_FALL || mode == EDGE_BOTH));
  assign sat  = (cnt_q == '1);
  assign pend = |cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   cnt_q <= '0;
    else if (clr)                cnt_q <= '0;
    else if (inc && !dec && !sat) cnt_q <= cnt_q + CNT_W'(1);
    else if (dec && !inc)        cnt_q <= cnt_q - CNT_W'(1);
  end

`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
  logic drop;
  assign drop = inc & ~dec & sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     ovf <= 1'b0;
    else if (clr)  ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/edge_event_collector.sv
// Edge event collector: NB_CH edge-detecting channels feeding a round-robin
// arbiter and a valid/ready output register. Define EDGE_EVENT_COLLECTOR_OVF_EN for ovf_o.
module edge_event_collector
  import edge_evt_pkg::*;
#(
  parameter int NB_CH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NB_CH-1:0]          edge_i,
  input  logic [2*NB_CH-1:0]        mode_i,
  input  logic                      clr_i,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [id_w(NB_CH)-1:0]    evt_id_o
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
  , output logic [NB_CH-1:0]        ovf_o
`endif
);

  localparam int ID_W = id_w(NB_CH);

  logic [NB_CH-1:0] pend, dec;
  logic [ID_W-1:0]  ptr_q, win;
  logic             found, take, grant;
  int               idx;

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    assign dec[i] = grant && (win == ID_W'(i));

    edge_evt_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk (clk_i),
      .rstn(rstn_i),
      .line(edge_i[i]),
      .mode(edge_mode_e'(mode_i[2*i +: 2])),
      .clr (clr_i),
      .dec (dec[i]),
      .pend(pend[i])
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
      , .ovf(ovf_o[i])
`endif
    );
  end

  // ptr_q is the first channel to look at, i.e. one past the last grant
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NB_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NB_CH) idx = idx - NB_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  // A flush suppresses new grants so nothing pending before it leaks out afterwards
  assign take  = !evt_valid_o || evt_ready_i;
  assign grant = take && !clr_i && found;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      ptr_q       <= '0;
    end else if (take) begin
      evt_valid_o <= grant;
      if (grant) begin
        evt_id_o <= win;
        ptr_q    <= (win == ID_W'(NB_CH-1)) ? '0 : win + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_event_collector.sv
// Bench for edge_event_collector: directed scenarios plus random traffic,
// all cycles checked against a queue-of-counts reference model.
module tb_edge_event_collector;
  import edge_evt_pkg::*;

  localparam int NB_CH = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int ID_W  = 2;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [NB_CH-1:0]     edge_i;
  logic [2*NB_CH-1:0]   mode_i;
  logic                 clr_i;
  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic [ID_W-1:0]      evt_id_o;
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
  logic [NB_CH-1:0]     ovf_o;
`endif

  always #5 clk_i = ~clk_i;

  edge_event_collector #(
    .NB_CH(NB_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .edge_i     (edge_i),
    .mode_i     (mode_i),
    .clr_i      (clr_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_id_o   (evt_id_o)
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
    , .ovf_o    (ovf_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending count per channel, a rotating start pointer, and
  // the raw line history that the synchroniser delays.
  int               pend_m [NB_CH];
  bit               ovf_m  [NB_CH];
  int               mptr, mid, m_w, m_c;
  bit               mvalid;
  bit               m_inc  [NB_CH];
  logic [NB_CH-1:0] hist   [SYNC+1];
  logic [NB_CH-1:0] m_last, m_prv;
  logic [1:0]       m_md;

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NB_CH; c++) begin pend_m[c] = 0; ovf_m[c] = 0; end
      for (int j = 0; j <= SYNC; j++) hist[j] = '0;
      mptr = 0; mid = 0; mvalid = 0;
    end else begin
      m_last = hist[SYNC-1];
      m_prv  = hist[SYNC];
      for (int c = 0; c < NB_CH; c++) begin
        m_md = mode_i[2*c +: 2];
        m_inc[c] = (m_last[c] && !m_prv[c] && m_md[0]) || (!m_last[c] && m_prv[c] && m_md[1]);
      end
      if (!mvalid || evt_ready_i) begin
        m_w = -1;
        if (!clr_i)
          for (int k = 0; k < NB_CH; k++) begin
            m_c = (mptr + k) % NB_CH;
            if (m_w < 0 && pend_m[m_c] > 0) m_w = m_c;
          end
        if (m_w >= 0) begin
          pend_m[m_w]--; mvalid = 1; mid = m_w; mptr = (m_w + 1) % NB_CH;
        end else mvalid = 0;
      end
      for (int c = 0; c < NB_CH; c++) begin
        if (clr_i) begin pend_m[c] = 0; ovf_m[c] = 0; end
        else if (m_inc[c]) begin
          if (pend_m[c] == CMAX) ovf_m[c] = 1;
          else pend_m[c]++;
        end
      end
      for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = edge_i;
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      chk("model_valid", evt_valid_o, mvalid);
      if (mvalid) chk("model_id", evt_id_o, mid);
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
      for (int c = 0; c < NB_CH; c++) chk("model_ovf", ovf_o[c], ovf_m[c]);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_i); #2; end
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick(3);
    rstn_i = 1'b1;
  endtask

  task automatic wait_valid(input string nm, input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (evt_valid_o) begin ok = 1; break; end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  task automatic count_ch(input int ch, input int cycles, output int n_ch, output int n_all);
    n_ch = 0; n_all = 0;
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid_o && evt_ready_i) begin
        n_all++;
        if (int'(evt_id_o) == ch) n_ch++;
      end
      tick();
    end
  endtask

  int nc, na;

  initial begin
    rstn_i = 1'b0; edge_i = '0; mode_i = '0; clr_i = 1'b0; evt_ready_i = 1'b0;
    tick(2);
    chk("reset_valid", evt_valid_o, 0);
    chk("reset_id", evt_id_o, 0);
    rstn_i = 1'b1;

    // single rising edge, latency from edge k
    mode_i = 8'h01; evt_ready_i = 1'b1;
    tick(2);
    edge_i[0] = 1'b1;
    tick(3);
    chk("lat_early", evt_valid_o, 0);
    tick();
    chk("lat_valid", evt_valid_o, 1);
    chk("lat_id", evt_id_o, 0);
    tick();
    chk("lat_one_cycle", evt_valid_o, 0);
    edge_i = '0;
    tick(6);

    // all channels both-edge, simultaneous toggle: ids in order
    do_reset();
    mode_i = 8'hFF; evt_ready_i = 1'b1;
    tick(2);
    edge_i = 4'hF;
    wait_valid("rr_timeout", 10);
    for (int k = 0; k < NB_CH; k++) begin
      chk("rr_valid", evt_valid_o, 1);
      chk("rr_id", evt_id_o, k);
      tick();
    end
    chk("rr_done", evt_valid_o, 0);

    // back-pressure holds the presented event
    evt_ready_i = 1'b0;
    edge_i = '0;
    wait_valid("stall_timeout", 10);
    chk("stall_id0", evt_id_o, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", evt_valid_o, 1);
      chk("stall_id", evt_id_o, 0);
    end
    evt_ready_i = 1'b1;
    tick();
    chk("stall_adv_valid", evt_valid_o, 1);
    chk("stall_adv_id", evt_id_o, 1);
    tick(6);

    // saturation: five rises on ch1 behind a held ch0 event
    do_reset();
    mode_i = 8'h05; evt_ready_i = 1'b0;
    tick(2);
    edge_i[0] = 1'b1;
    wait_valid("sat_timeout", 10);
    chk("sat_held_id", evt_id_o, 0);
    for (int p = 0; p < 5; p++) begin
      edge_i[1] = 1'b1; tick(2);
      edge_i[1] = 1'b0; tick(2);
    end
    tick(4);
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
    chk("sat_ovf1", ovf_o[1], 1);
`endif
    evt_ready_i = 1'b1;
    count_ch(1, 20, nc, na);
    chk("sat_ch1_count", nc, 3);
    chk("sat_total", na, 4);

    // flush with an event held and three pending
    edge_i = '0; mode_i = 8'h55; evt_ready_i = 1'b0;
    tick(4);
    chk("clr_idle", evt_valid_o, 0);
    edge_i = 4'hF;
    wait_valid("clr_timeout", 10);
    tick(4);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("clr_held", evt_valid_o, 1);
`ifdef EDGE_EVENT_COLLECTOR_OVF_EN
    chk("clr_ovf", ovf_o, 0);
`endif
    evt_ready_i = 1'b1;
    count_ch(0, 8, nc, na);
    chk("clr_delivered", na, 1);
    chk("clr_empty", evt_valid_o, 0);

    // falling-only on ch2, then switched off mid-stream
    mode_i = 8'h20; evt_ready_i = 1'b0;
    tick(4);
    for (int p = 0; p < 3; p++) begin
      edge_i[2] = 1'b0; tick(2);
      edge_i[2] = 1'b1; tick(2);
    end
    tick(4);
    chk("fall_held_id", evt_id_o, 2);
    mode_i = 8'h00;
    for (int p = 0; p < 2; p++) begin
      edge_i[2] = 1'b0; tick(2);
      edge_i[2] = 1'b1; tick(2);
    end
    tick(4);
    evt_ready_i = 1'b1;
    count_ch(2, 12, nc, na);
    chk("fall_ch2_count", nc, 3);
    chk("fall_total", na, 3);

    // line already high across reset release
    evt_ready_i = 1'b0; mode_i = 8'h01; edge_i = 4'h1;
    do_reset();
    evt_ready_i = 1'b1;
    wait_valid("rst_high_timeout", 10);
    chk("rst_high_id", evt_id_o, 0);
    tick(3);
    chk("rst_high_once", evt_valid_o, 0);

    // random traffic against the model
    mode_i = $urandom();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NB_CH; c++)
        if ($urandom_range(3) == 0) edge_i[c] = ~edge_i[c];
      if ($urandom_range(49) == 0) mode_i = $urandom();
      evt_ready_i = ($urandom_range(9) < 7);
      clr_i = ($urandom_range(99) == 0);
      if (cyc == 1500) begin
        clr_i = 1'b0;
        edge_i = $urandom();
        do_reset();
      end else tick();
    end
    clr_i = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
